// File: rtl/acc_wb_pkg.sv
// Shared opcode encoding and opcode-class helpers for the writeback stage.
// Any opcode value without an entry here is treated as a no-op.
package acc_wb_pkg;

  localparam int OPW = 4;

  typedef enum logic [OPW-1:0] {
    OP_NOP = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_NOT = 4'h3,
    OP_XOR = 4'h4,
    OP_OR  = 4'h5,
    OP_AND = 4'h6,
    OP_RR  = 4'h7,
    OP_RL  = 4'h8,
    OP_INC = 4'h9,
    OP_DEC = 4'hA,
    OP_LD  = 4'hB,
    OP_ST  = 4'hC,
    OP_RST = 4'hD
  } opcode_e;

  localparam logic [OPW-1:0] OP_UNDEF = 4'hF;

  function automatic logic is_arith_c(logic [OPW-1:0] op);
    return (op == OP_ADD) || (op == OP_INC);
  endfunction

  function automatic logic is_arith_b(logic [OPW-1:0] op);
    return (op == OP_SUB) || (op == OP_DEC);
  endfunction

  function automatic logic is_acc_wr(logic [OPW-1:0] op);
    return is_arith_c(op) || is_arith_b(op) ||
           (op == OP_NOT) || (op == OP_XOR) || (op == OP_OR) || (op == OP_AND) ||
           (op == OP_RR)  || (op == OP_RL)  || (op == OP_LD);
  endfunction

endpackage

// File: rtl/acc_wb_store_queue.sv
// Small store FIFO: push side with full, pop side as valid/ready toward data memory.
// The head is zeroed while empty, so the bus reads 0 after reset.
module store_queue #(
  parameter int DEPTH = 2,
  parameter int AW    = 8,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [AW-1:0] push_addr_i,
  input  logic [DW-1:0] push_data_i,
  output logic          full_o,
  output logic          empty_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] data_o
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        head;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign valid_o = !empty_o;
  assign do_push = push_i && !full_o;
  assign do_pop  = valid_o && ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; the head is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= {push_addr_i, push_data_i};
  end

  assign head   = mem_q[rd_ptr_q];
  assign addr_o = valid_o ? head.addr : '0;
  assign data_o = valid_o ? head.data : '0;

endmodule

// File: rtl/acc_wb.sv
// Writeback stage: accumulator and C/B/Z flags fed back to the ALU, plus a
// store queue draining to data memory and the PC-hold stall interlock.
module acc_wb
  import acc_wb_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int IWIDTH   = 4,
  parameter int AWIDTH   = 8,
  parameter int SQ_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IWIDTH-1:0] instr,
  input  logic              wb_en,
  input  logic [WIDTH-1:0]  alu_out,
  input  logic              alu_c_out,
  input  logic              alu_b_out,
  input  logic [AWIDTH-1:0] st_addr,
  output logic [WIDTH-1:0]  acc,
  output logic              c_flag,
  output logic              b_flag,
  output logic              z_flag,
  output logic              stall,
  output logic              mem_wr_valid,
  input  logic              mem_wr_ready,
  output logic [AWIDTH-1:0] mem_wr_addr,
  output logic [WIDTH-1:0]  mem_wr_data
);

  logic [OPW-1:0]   op;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             c_q, c_d, b_q, b_d, z_q, z_d;
  logic             is_st, is_ld, is_rst, retire;
  logic             sq_full, sq_empty, sq_push;

  // Opcode bits above the defined encoding make the instruction undefined.
  generate
    if (IWIDTH > OPW) begin : g_wide
      assign op = (|instr[IWIDTH-1:OPW]) ? OP_UNDEF : instr[OPW-1:0];
    end else begin : g_narrow
      assign op = OPW'(instr);
    end
  endgenerate

  assign is_st  = (op == OP_ST);
  assign is_ld  = (op == OP_LD);
  assign is_rst = (op == OP_RST);

  // Registered queue state only: a same-cycle pop never frees a slot for this ST,
  // and a LD waits until every older store has landed.
  assign stall   = wb_en && ((is_st && sq_full) || (is_ld && !sq_empty));
  assign retire  = wb_en && !stall;
  assign sq_push = retire && is_st;

  always_comb begin
    acc_d = acc_q;
    c_d   = c_q;
    b_d   = b_q;
    z_d   = z_q;
    if (retire) begin
      if (is_rst) begin
        acc_d = '0;
        c_d   = 1'b0;
        b_d   = 1'b0;
        z_d   = 1'b0;
      end else if (is_acc_wr(op)) begin
        acc_d = alu_out;
        z_d   = (alu_out == '0);
        if (is_arith_c(op)) c_d = alu_c_out;
        if (is_arith_b(op)) b_d = alu_b_out;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      c_q   <= 1'b0;
      b_q   <= 1'b0;
      z_q   <= 1'b0;
    end else begin
      acc_q <= acc_d;
      c_q   <= c_d;
      b_q   <= b_d;
      z_q   <= z_d;
    end
  end

  assign acc    = acc_q;
  assign c_flag = c_q;
  assign b_flag = b_q;
  assign z_flag = z_q;

  store_queue #(
    .DEPTH (SQ_DEPTH),
    .AW    (AWIDTH),
    .DW    (WIDTH)
  ) u_sq (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (sq_push),
    .push_addr_i (st_addr),
    .push_data_i (acc_q),
    .full_o      (sq_full),
    .empty_o     (sq_empty),
    .valid_o     (mem_wr_valid),
    .ready_i     (mem_wr_ready),
    .addr_o      (mem_wr_addr),
    .data_o      (mem_wr_data)
  );

endmodule
